// File: rtl/count_access_arbiter.sv
// Arbitrates Wishbone and logic-analyzer accesses to the shared count register
// and gates the free-run increment; one access in flight, round-robin on ties.
module count_access_arbiter #(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wb_valid,
  input  logic            wb_we,
  input  logic [3:0]      wb_sel,
  input  logic [BITS-1:0] wb_wdata,
  output logic            wb_ready,
  output logic [BITS-1:0] wb_rdata,
  input  logic            la_valid,
  input  logic [BITS-1:0] la_mask,
  input  logic [BITS-1:0] la_data,
  output logic            la_ack,
  output logic [BITS-1:0] la_rdata,
  input  logic            run_en,
  input  logic [BITS-1:0] cnt_value,
  output logic            cnt_load,
  output logic [BITS-1:0] cnt_load_mask,
  output logic [BITS-1:0] cnt_load_data,
  output logic            cnt_inc,
  output logic [1:0]      grant
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_t;

  state_t          state;
  logic            last_la;
  logic            win_la;
  logic            pick_la;
  logic            start;
  logic            load_next;
  logic [BITS-1:0] wb_mask;
  logic [BITS-1:0] pick_mask;
  logic [BITS-1:0] pick_data;

  // Byte lane k drives bits 8k+7:8k; lanes above BITS simply fall off.
  always_comb begin
    wb_mask = '0;
    for (int i = 0; i < BITS; i++) begin
      wb_mask[i] = wb_we & wb_sel[i[4:3]];
    end
  end

  assign pick_la   = la_valid & (~wb_valid | ~last_la);
  assign pick_mask = pick_la ? la_mask : wb_mask;
  assign pick_data = pick_la ? la_data : wb_wdata;
  assign start     = (state == IDLE) & (wb_valid | la_valid);
  assign load_next = start & (|pick_mask);

  // Strobes are decided at IDLE exit so the load lands exactly in SERVE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      last_la       <= 1'b1;
      win_la        <= 1'b0;
      wb_ready      <= 1'b0;
      la_ack        <= 1'b0;
      cnt_load      <= 1'b0;
      cnt_load_mask <= '0;
      cnt_load_data <= '0;
      cnt_inc       <= 1'b0;
      grant         <= 2'b00;
      wb_rdata      <= '0;
      la_rdata      <= '0;
    end else begin
      wb_ready      <= 1'b0;
      la_ack        <= 1'b0;
      cnt_load      <= load_next;
      cnt_load_mask <= '0;
      cnt_load_data <= '0;
      cnt_inc       <= run_en & ~load_next;
      case (state)
        IDLE: begin
          if (start) begin
            win_la <= pick_la;
            grant  <= pick_la ? 2'b10 : 2'b01;
            state  <= SERVE;
            if (load_next) begin
              cnt_load_mask <= pick_mask;
              cnt_load_data <= pick_data;
            end
          end
        end
        SERVE: begin
          // cnt_value still holds the pre-load value during this cycle.
          if (win_la) begin
            la_rdata <= cnt_value;
            la_ack   <= 1'b1;
          end else begin
            wb_rdata <= cnt_value;
            wb_ready <= 1'b1;
          end
          state <= ACK;
        end
        ACK: begin
          last_la <= win_la;
          grant   <= 2'b00;
          state   <= IDLE;
        end
        default: begin
          grant <= 2'b00;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
